// File: rtl/video_pkg.sv
// Shared raster constants for the 1280x1024@60 Hz mode and a coordinate window helper.
package video_pkg;

    localparam int COORD_W = 12;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FP_DEF     = 48;
    localparam int H_SYNC_DEF   = 112;
    localparam int H_BP_DEF     = 248;

    localparam int V_ACTIVE_DEF = 1024;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 38;

    // True when lo <= c < hi.
    function automatic logic in_span(input logic [COORD_W-1:0] c,
                                     input int unsigned lo,
                                     input int unsigned hi);
        return (32'(c) >= lo) && (32'(c) < hi);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register with a per-bit reset value; N = 0 is a plain wire.
module sync_delay #(
    parameter int             N       = 2,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (N == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_pipe
            logic [W-1:0] stage_q [N];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, registered coordinate decode,
// sync/blank delay line aligned to the pixel pipeline, and a per-frame update strobe.
module vga_timing
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b1,
    parameter int   PIPE     = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        update,
    output logic [7:0]  frame
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_START = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || PIPE < 0 || PIPE > 7) begin : g_bad_params
            $error("vga_timing: totals must fit 12-bit counters and PIPE must be 0..7");
        end
    endgenerate

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic [COORD_W-1:0] x_q, y_q;
    logic               active_q, active_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               update_q, update_d;
    logic [7:0]         frame_q;

    always_comb begin
        h_cnt_d = h_cnt_q + ONE;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
        end
    end

    // Decode uses the counter value that is being registered into x/y this cycle.
    always_comb begin
        active_d = in_span(h_cnt_q, 0, H_ACTIVE) && in_span(v_cnt_q, 0, V_ACTIVE);
        hs_d     = in_span(h_cnt_q, HS_START, HS_START + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_d     = in_span(v_cnt_q, VS_START, VS_START + V_SYNC) ? SYNC_POL : ~SYNC_POL;
        update_d = (h_cnt_q == '0) && (v_cnt_q == V_START);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            update_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            x_q      <= h_cnt_q;
            y_q      <= v_cnt_q;
            active_q <= active_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            update_q <= update_d;
            if (update_d) frame_q <= frame_q + 8'd1;
        end
    end

    sync_delay #(
        .N       (PIPE),
        .W       (3),
        .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_sync_delay (
        .clock (clock),
        .reset (reset),
        .d_i   ({hs_q, vs_q, active_q}),
        .q_o   ({hsync, vsync, blank_n})
    );

    assign x      = x_q;
    assign y      = y_q;
    assign active = active_q;
    assign update = update_q;
    assign frame  = frame_q;

endmodule
